// File: rtl/vmm_pkg.sv
// Shared mode numbers, FSM state type and width helper for the video mode multiplexer.
package vmm_pkg;

  localparam int MODE_RAW  = 0;
  localparam int MODE_GREY = 1;
  localparam int MODE_BLUR = 5;
  localparam int MODE_EDGE = 6;
  localparam int MODE_GAME = 7;

  typedef enum logic [0:0] {
    WAIT_SOF = 1'b0,
    RUN      = 1'b1
  } vmm_state_e;

  // Bits needed to index n items; never less than 1 so vectors stay legal.
  function automatic int clog2(input int n);
    int w;
    w = 1;
    while ((1 << w) < n) w++;
    return w;
  endfunction

endpackage

// File: rtl/vmm_if.sv
// Pixel-stream bundle between the processing blocks, the mode mux and the cursor overlay.
interface vmm_if #(
  parameter int PIX_W     = 8,
  parameter int NUM_CH    = 3,
  parameter int NUM_MODES = 8,
  parameter int MODE_W    = 3,
  parameter int ROW_W     = 9,
  parameter int COL_W     = 10
);
  import vmm_pkg::*;

  logic [MODE_W-1:0]                 mode_req;
  logic                              in_valid;
  logic                              in_sof;
  logic [NUM_MODES*NUM_CH*PIX_W-1:0] proc_pix;
  logic [NUM_MODES-1:0]              proc_valid;
  logic [NUM_CH*PIX_W-1:0]           out_pix;
  logic                              out_valid;
  logic [ROW_W-1:0]                  out_row;
  logic [COL_W-1:0]                  out_col;
  logic [MODE_W-1:0]                 active_mode;
  logic                              mode_chg;
  logic                              eof;
  logic                              frame_err;
  vmm_state_e                        dbg_state;

  // in_valid and out_valid are strobes with no ready: a beat is consumed in the
  // cycle it is presented and every out_valid beat must be taken by the overlay.
  modport master (
    output mode_req, in_valid, in_sof, proc_pix, proc_valid,
    input  out_pix, out_valid, out_row, out_col, active_mode, mode_chg, eof,
           frame_err, dbg_state
  );

  modport slave (
    input  mode_req, in_valid, in_sof, proc_pix, proc_valid,
    output out_pix, out_valid, out_row, out_col, active_mode, mode_chg, eof,
           frame_err, dbg_state
  );

endinterface

// File: rtl/vmm_raster_cnt.sv
// Active-area row/column tracker: position of the current beat, last-pixel and border decode.
module vmm_raster_cnt #(
  parameter int H_ACTIVE = 640,
  parameter int V_ACTIVE = 480,
  parameter int PAD      = 2,
  parameter int ROW_W    = 9,
  parameter int COL_W    = 10
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             advance_i,
  input  logic             restart_i,
  output logic [ROW_W-1:0] row_o,
  output logic [COL_W-1:0] col_o,
  output logic             last_o,
  output logic             border_o
);

  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(V_ACTIVE - 1);
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(H_ACTIVE - 1);

  logic [ROW_W-1:0] row_q, row_d;
  logic [COL_W-1:0] col_q, col_d;

  // row_q/col_q hold the position the next beat will take; a restart forces (0,0).
  always_comb begin
    row_o    = restart_i ? '0 : row_q;
    col_o    = restart_i ? '0 : col_q;
    last_o   = (row_o == ROW_LAST) && (col_o == COL_LAST);
    border_o = (PAD > 0) &&
               ((int'(row_o) < PAD) || (int'(row_o) >= V_ACTIVE - PAD) ||
                (int'(col_o) < PAD) || (int'(col_o) >= H_ACTIVE - PAD));
    row_d    = row_o;
    col_d    = col_o;
    if (col_o == COL_LAST) begin
      col_d = '0;
      row_d = (row_o == ROW_LAST) ? '0 : row_o + 1'b1;
    end else begin
      col_d = col_o + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      row_q <= '0;
      col_q <= '0;
    end else if (advance_i) begin
      row_q <= row_d;
      col_q <= col_d;
    end
  end

endmodule

// File: rtl/video_mode_mux.sv
// Per-frame selection of one processed pixel stream with stall hold, border padding and
// frame tracking; sits between the processing blocks and the cursor overlay.
module video_mode_mux
  import vmm_pkg::*;
#(
  parameter int                   PIX_W     = 8,
  parameter int                   NUM_CH    = 3,
  parameter int                   NUM_MODES = 8,
  parameter int                   MODE_W    = 3,
  parameter int                   H_ACTIVE  = 640,
  parameter int                   V_ACTIVE  = 480,
  parameter int                   PAD       = 2,
  parameter logic [NUM_MODES-1:0] PAD_MASK  = NUM_MODES'(1 << MODE_BLUR),
  parameter logic [PIX_W-1:0]     PAD_VAL   = '0
) (
  input logic  CLOCK_50,
  input logic  RESET_N,
  vmm_if.slave bus
);

  localparam int ROW_W = clog2(V_ACTIVE);
  localparam int COL_W = clog2(H_ACTIVE);
  localparam int PB    = NUM_CH * PIX_W;

  vmm_state_e        state_q, state_d;
  logic [MODE_W-1:0] pending_q, active_q;
  logic [PB-1:0]     hold_q, hold_d;
  logic [PB-1:0]     out_pix_q;
  logic [ROW_W-1:0]  out_row_q;
  logic [COL_W-1:0]  out_col_q;
  logic              out_valid_q, mode_chg_q, eof_q, frame_err_q;

  logic              accept, commit, ferr_set;
  logic [ROW_W-1:0]  cur_row;
  logic [COL_W-1:0]  cur_col;
  logic              last, in_border;
  logic [MODE_W-1:0] sel_mode;
  logic [PB-1:0]     sel_pix, base_pix, emit_pix;
  logic              sel_v, sel_pad;

  vmm_raster_cnt #(
    .H_ACTIVE (H_ACTIVE),
    .V_ACTIVE (V_ACTIVE),
    .PAD      (PAD),
    .ROW_W    (ROW_W),
    .COL_W    (COL_W)
  ) u_raster (
    .clk_i     (CLOCK_50),
    .rst_ni    (RESET_N),
    .advance_i (accept),
    .restart_i (commit),
    .row_o     (cur_row),
    .col_o     (cur_col),
    .last_o    (last),
    .border_o  (in_border)
  );

  always_comb begin
    state_d  = state_q;
    accept   = 1'b0;
    commit   = 1'b0;
    ferr_set = 1'b0;
    unique case (state_q)
      WAIT_SOF: begin
        if (bus.in_valid && bus.in_sof) begin
          accept  = 1'b1;
          commit  = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        if (bus.in_valid) begin
          accept = 1'b1;
          if (bus.in_sof) begin
            commit   = 1'b1;
            ferr_set = 1'b1;
          end
        end
      end
      default: state_d = WAIT_SOF;
    endcase
    if (accept && last) state_d = WAIT_SOF;
  end

  // A committing sof beat already uses the new mode and a freshly cleared hold.
  always_comb begin
    sel_mode = commit ? pending_q : active_q;
    sel_pix  = '0;
    sel_v    = 1'b0;
    sel_pad  = 1'b0;
    for (int m = 0; m < NUM_MODES; m++) begin
      if (sel_mode == MODE_W'(m)) begin
        sel_pix = bus.proc_pix[m*PB +: PB];
        sel_v   = bus.proc_valid[m];
        sel_pad = PAD_MASK[m];
      end
    end
    base_pix = commit ? '0 : hold_q;
    hold_d   = sel_v ? sel_pix : base_pix;
    emit_pix = (sel_pad && in_border) ? {NUM_CH{PAD_VAL}} : hold_d;
  end

  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q     <= WAIT_SOF;
      pending_q   <= '0;
      active_q    <= '0;
      hold_q      <= '0;
      out_pix_q   <= '0;
      out_row_q   <= '0;
      out_col_q   <= '0;
      out_valid_q <= 1'b0;
      mode_chg_q  <= 1'b0;
      eof_q       <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (int'(bus.mode_req) < NUM_MODES) pending_q <= bus.mode_req;
      if (commit) active_q <= pending_q;
      if (accept) begin
        hold_q    <= hold_d;
        out_pix_q <= emit_pix;
        out_row_q <= cur_row;
        out_col_q <= cur_col;
      end
      out_valid_q <= accept;
      eof_q       <= accept && last;
      mode_chg_q  <= commit && (pending_q != active_q);
      if (ferr_set) frame_err_q <= 1'b1;
    end
  end

  assign bus.out_pix     = out_pix_q;
  assign bus.out_valid   = out_valid_q;
  assign bus.out_row     = out_row_q;
  assign bus.out_col     = out_col_q;
  assign bus.active_mode = active_q;
  assign bus.mode_chg    = mode_chg_q;
  assign bus.eof         = eof_q;
  assign bus.frame_err   = frame_err_q;
  assign bus.dbg_state   = state_q;

endmodule

// File: tb/tb_video_mode_mux.sv
// Bench for video_mode_mux on an 8x4 raster: directed vector tables, hand sequences for
// mode commit, frame restart and reset, then random traffic against a frame-level model.
module tb_video_mode_mux;
  import vmm_pkg::*;

  localparam int PIX_W = 8;
  localparam int NUM_CH = 3;
  localparam int NUM_MODES = 8;
  localparam int MODE_W = 4;
  localparam int H = 8;
  localparam int V = 4;
  localparam int PAD = 1;
  localparam logic [7:0] PAD_MASK = 8'h20;
  localparam int PB = NUM_CH * PIX_W;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  vmm_if #(.PIX_W(PIX_W), .NUM_CH(NUM_CH), .NUM_MODES(NUM_MODES), .MODE_W(MODE_W),
           .ROW_W(2), .COL_W(3)) bus ();

  video_mode_mux #(
    .PIX_W(PIX_W), .NUM_CH(NUM_CH), .NUM_MODES(NUM_MODES), .MODE_W(MODE_W),
    .H_ACTIVE(H), .V_ACTIVE(V), .PAD(PAD), .PAD_MASK(PAD_MASK), .PAD_VAL(8'h00)
  ) dut (
    .CLOCK_50 (clk),
    .RESET_N  (rst_n),
    .bus      (bus)
  );

  // ---------------- scoreboard / model state ----------------
  int checks = 0;
  int errors = 0;
  logic [28:0] exp_q[$];

  bit          m_in_frame;
  int          m_idx;
  logic [3:0]  m_pending, m_active;
  logic [23:0] m_hold;
  bit          m_ferr;
  bit          e_valid, e_chg, e_eof;
  logic [23:0] e_pix;
  int          e_row, e_col;

  typedef struct {
    bit          sof;
    logic [3:0]  mode;
    bit          pv;
    logic [23:0] d;
    bit          e_valid;
    logic [23:0] e_pix;
    logic [1:0]  e_row;
    logic [2:0]  e_col;
    bit          e_eof;
    bit          e_chg;
  } vec_t;
  vec_t vecs[64];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    m_in_frame = 1'b0;
    m_idx = 0;
    m_pending = '0;
    m_active = '0;
    m_hold = '0;
    m_ferr = 1'b0;
    e_valid = 1'b0;
    e_chg = 1'b0;
    e_eof = 1'b0;
    e_pix = '0;
    e_row = 0;
    e_col = 0;
    exp_q.delete();
  endfunction

  // Frame-level model: linear beat index, row/col by division.
  function automatic void model_step();
    int r, c;
    logic [2:0] a;
    logic [23:0] px;
    e_valid = 1'b0;
    e_chg = 1'b0;
    e_eof = 1'b0;
    if (bus.in_valid && (bus.in_sof || m_in_frame)) begin
      if (bus.in_sof) begin
        if (m_in_frame) m_ferr = 1'b1;
        e_chg = (m_pending != m_active);
        m_active = m_pending;
        m_hold = '0;
        m_idx = 0;
      end
      a = m_active[2:0];
      r = m_idx / H;
      c = m_idx % H;
      if (bus.proc_valid[a]) m_hold = bus.proc_pix[a*PB +: PB];
      px = m_hold;
      if (PAD_MASK[a] && (r < PAD || r >= V - PAD || c < PAD || c >= H - PAD)) px = '0;
      e_valid = 1'b1;
      e_pix = px;
      e_row = r;
      e_col = c;
      exp_q.push_back({r[1:0], c[2:0], px});
      m_idx++;
      m_in_frame = (m_idx < H * V);
      e_eof = !m_in_frame;
    end
    if (int'(bus.mode_req) < NUM_MODES) m_pending = bus.mode_req;
  endfunction

  // One clock: advance the model on the current inputs, then compare just after the edge.
  task automatic tick();
    logic [28:0] got;
    if (!rst_n) model_reset();
    else model_step();
    @(posedge clk);
    #1;
    check("out_valid", bus.out_valid, e_valid);
    check("active_mode", bus.active_mode, m_active);
    check("mode_chg", bus.mode_chg, e_chg);
    check("eof", bus.eof, e_eof);
    check("frame_err", bus.frame_err, m_ferr);
    got = {bus.out_row, bus.out_col, bus.out_pix};
    if (bus.out_valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_underflow: got beat 0x%0h expected no beat", got);
      end else begin
        check("sb_beat", got, exp_q.pop_front());
      end
    end else begin
      check("held_beat", got, {e_row[1:0], e_col[2:0], e_pix});
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive(input bit v, input bit s, input logic [3:0] mode);
    bus.in_valid = v;
    bus.in_sof = s;
    bus.mode_req = mode;
    for (int m = 0; m < NUM_MODES; m++) bus.proc_pix[m*PB +: PB] = 24'($urandom);
    bus.proc_valid = 8'($urandom);
  endtask

  task automatic set_slot(input int m, input bit pv, input logic [23:0] d);
    bus.proc_pix[m*PB +: PB] = d;
    bus.proc_valid[m] = pv;
  endtask

  task automatic run_frame_beats(input int first, input int last_i, input logic [3:0] mode);
    for (int i = first; i <= last_i; i++) begin
      drive(1'b1, i == 0, mode);
      tick();
    end
  endtask

  function automatic void fill_vecs();
    int k;
    bit border;
    for (int i = 0; i < 32; i++) begin
      vecs[i].sof = (i == 0);
      vecs[i].mode = 4'(MODE_RAW);
      vecs[i].pv = 1'b1;
      vecs[i].d = {3{8'(i)}};
      vecs[i].e_valid = 1'b1;
      vecs[i].e_pix = {3{8'(i)}};
      vecs[i].e_row = 2'(i / 8);
      vecs[i].e_col = 3'(i % 8);
      vecs[i].e_eof = (i == 31);
      vecs[i].e_chg = 1'b0;
    end
    for (int i = 0; i < 32; i++) begin
      k = i % 4;
      border = (i / 8 == 0) || (i / 8 == 3) || (i % 8 == 0) || (i % 8 == 7);
      vecs[32+i].sof = (i == 0);
      vecs[32+i].mode = 4'(MODE_BLUR);
      vecs[32+i].pv = (k == 0) || (k == 3);
      vecs[32+i].d = {3{8'((k + 1) * 10)}};
      vecs[32+i].e_valid = 1'b1;
      vecs[32+i].e_pix = border ? 24'h0 : {3{(k == 3) ? 8'd40 : 8'd10}};
      vecs[32+i].e_row = 2'(i / 8);
      vecs[32+i].e_col = 3'(i % 8);
      vecs[32+i].e_eof = (i == 31);
      vecs[32+i].e_chg = (i == 0);
    end
  endfunction

  task automatic run_table(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      drive(1'b1, vecs[i].sof, vecs[i].mode);
      set_slot(int'(vecs[i].mode), vecs[i].pv, vecs[i].d);
      tick();
      check("tv_valid", bus.out_valid, vecs[i].e_valid);
      check("tv_pix", bus.out_pix, vecs[i].e_pix);
      check("tv_pos", {bus.out_row, bus.out_col}, {vecs[i].e_row, vecs[i].e_col});
      check("tv_eof", bus.eof, vecs[i].e_eof);
      check("tv_chg", bus.mode_chg, vecs[i].e_chg);
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    bit rv, rs;
    fill_vecs();
    model_reset();
    drive(1'b0, 1'b0, 4'd0);
    rst_n = 1'b0;
    repeat (3) tick();
    check("rst_state", bus.dbg_state, WAIT_SOF);
    check("rst_outs", {bus.out_valid, bus.out_pix}, 25'h0);
    rst_n = 1'b1;

    // beats before the first sof are dropped; an out-of-range request is ignored
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 1'b0, 4'd9);
      tick();
      check("pre_sof_drop", bus.out_valid, 1'b0);
    end

    // raw frame: output equals beat index, eof on the last beat
    drive(1'b0, 1'b0, 4'(MODE_RAW));
    tick();
    run_table(0, 31);
    drive(1'b1, 1'b0, 4'(MODE_RAW));
    tick();
    check("post_eof_drop", bus.out_valid, 1'b0);
    check("post_eof_state", bus.dbg_state, WAIT_SOF);

    // mode request changes mid-frame; commit waits for the next sof
    drive(1'b0, 1'b0, 4'(MODE_RAW));
    tick();
    for (int i = 0; i < 32; i++) begin
      drive(1'b1, i == 0, (i < 5) ? 4'(MODE_RAW) : 4'(MODE_EDGE));
      tick();
      check("t2_active_hold", bus.active_mode, 4'(MODE_RAW));
    end
    drive(1'b0, 1'b0, 4'(MODE_EDGE));
    tick();
    drive(1'b1, 1'b1, 4'(MODE_EDGE));
    set_slot(MODE_EDGE, 1'b1, 24'hABCDEF);
    tick();
    check("t2_mode_chg", bus.mode_chg, 1'b1);
    check("t2_active", bus.active_mode, 4'(MODE_EDGE));
    check("t2_slice6", bus.out_pix, 24'hABCDEF);
    run_frame_beats(1, 31, 4'(MODE_EDGE));

    // padded blur mode with stalling processor
    drive(1'b0, 1'b0, 4'(MODE_BLUR));
    tick();
    run_table(32, 63);

    // sof arriving mid-frame restarts the raster and latches frame_err
    drive(1'b0, 1'b0, 4'(MODE_RAW));
    tick();
    run_frame_beats(0, 11, 4'(MODE_RAW));
    drive(1'b1, 1'b1, 4'(MODE_RAW));
    tick();
    check("t4_ferr", bus.frame_err, 1'b1);
    check("t4_restart_pos", {bus.out_valid, bus.out_row, bus.out_col}, 6'b1_00_000);
    check("t4_state", bus.dbg_state, RUN);
    run_frame_beats(1, 31, 4'(MODE_RAW));
    drive(1'b0, 1'b0, 4'(MODE_RAW));
    repeat (3) tick();
    check("t4_ferr_sticky", bus.frame_err, 1'b1);

    // out-of-range requests leave the pending mode untouched
    drive(1'b0, 1'b0, 4'(MODE_GREY));
    tick();
    drive(1'b0, 1'b0, 4'd9);
    repeat (3) tick();
    drive(1'b1, 1'b1, 4'd9);
    tick();
    check("t5_active", bus.active_mode, 4'(MODE_GREY));
    run_frame_beats(1, 31, 4'd15);

    // asynchronous reset at beat 17
    drive(1'b0, 1'b0, 4'(MODE_GAME));
    tick();
    run_frame_beats(0, 16, 4'(MODE_GAME));
    drive(1'b1, 1'b0, 4'(MODE_GAME));
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_pixbus", {bus.out_valid, bus.out_pix}, 25'h0);
    check("async_rst_ctrl", {bus.out_row, bus.out_col, bus.active_mode, bus.mode_chg,
                             bus.eof, bus.frame_err, bus.dbg_state}, 13'h0);
    model_reset();
    repeat (2) tick();
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 1'b0, 4'(MODE_GAME));
      tick();
      check("t6_drop", bus.out_valid, 1'b0);
    end
    run_frame_beats(0, 31, 4'(MODE_GAME));

    // random traffic against the model
    for (int n = 0; n < 3000; n++) begin
      rv = ($urandom_range(0, 99) < 75);
      rs = m_in_frame ? ($urandom_range(0, 99) < 3) : ($urandom_range(0, 99) < 30);
      drive(rv, rs, 4'($urandom_range(0, 15)));
      rst_n = ($urandom_range(0, 499) != 0);
      tick();
    end
    rst_n = 1'b1;
    drive(1'b0, 1'b0, 4'd0);
    tick();
    check("sb_drained", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

endmodule
